// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
package imem_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  // sll $0,$0,0 -- harmless filler returned for faulting fetches
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Width of the word index for a memory of the given depth
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// Plain synchronous array: one write port, one registered read port.
module imem_ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port; read data holds when re is low
  // NOTE: the array and read register have no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory with stall hold, fault decode and a
// streaming load port that fills the array from word 0.
module imem_sync
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done
);

  localparam int IDX_W = idx_width(DEPTH);

  state_t             state, next_state;
  logic [IDX_W-1:0]   ptr;
  logic               wr_en;
  logic               load_term;
  logic               accept;
  logic               addr_fault;
  logic [IDX_W-1:0]   word_idx;
  logic [DATA_W-1:0]  ram_rdata;

  assign word_idx   = fetch_addr[IDX_W+1:2];
  assign addr_fault = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[ADDR_W-1:IDX_W+2]);
  assign wr_en      = (state == LOAD) && load_valid;
  assign load_term  = load_last || (ptr == IDX_W'(DEPTH - 1));
  assign accept     = fetch_req && fetch_ready && !fetch_stall;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // Next-state decode: load_start opens a load, the terminating write closes it
  // NOTE: next_state takes a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (load_start)          next_state = LOAD;
      LOAD:    if (wr_en && load_term)  next_state = RUN;
      default:                          next_state = RUN;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    load_ready  = (state == LOAD);
    fetch_ready = (state == RUN) && !load_start;
  end

  // Write pointer and the load_done pulse following the terminating write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= wr_en && load_term;
      if (state == RUN && load_start) ptr <= '0;
      else if (wr_en)                 ptr <= ptr + IDX_W'(1);
    end
  end

  // Fetch status: cleared on entering or sitting in LOAD, held on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (state == LOAD || load_start) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (!fetch_stall) begin
      fetch_valid <= accept;
      fetch_fault <= accept && addr_fault;
    end
  end

  // Faults and idle cycles show NOP_WORD; the RAM read register holds on stall
  assign fetch_instr = (fetch_valid && !fetch_fault) ? ram_rdata : NOP_WORD;

  imem_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ptr),
    .wdata (load_data),
    .re    (accept),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_imem_sync.sv
// Directed self-checking bench for imem_sync (DEPTH=128).
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;

  int n_cmp  = 0;
  int n_fail = 0;

  imem_sync #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .DEPTH    (128),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_stall (fetch_stall),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_expect(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic fault);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    check({tag, "_instr"}, fetch_instr, instr);
    check({tag, "_fault"}, 32'(fetch_fault), 32'(fault));
  endtask

  logic [31:0] prog [3];

  initial begin
    prog[0] = 32'h8C25_0003;
    prog[1] = 32'h00A1_2820;
    prog[2] = 32'h00A1_2820;

    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    #12;
    check("rst_valid",  32'(fetch_valid), 32'd0);
    check("rst_instr",  fetch_instr, 32'h0);
    check("rst_fault",  32'(fetch_fault), 32'd0);
    check("rst_done",   32'(load_done), 32'd0);
    check("rst_lready", 32'(load_ready), 32'd0);
    check("rst_fready", 32'(fetch_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Auto-terminating full load of 128 words without load_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("auto_lready_on", 32'(load_ready), 32'd1);
    for (int i = 0; i < 128; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hC0DE_0000 | 32'(i);
      tick();
      if (i == 126) check("auto_lready_126", 32'(load_ready), 32'd1);
    end
    check("auto_lready_off", 32'(load_ready), 32'd0);
    check("auto_done",       32'(load_done), 32'd1);
    load_data = 32'hDEAD_BEEF;
    tick();
    load_valid = 1'b0;
    check("auto_done_clr", 32'(load_done), 32'd0);
    fetch_expect("auto_w0",   32'h0,     32'hC0DE_0000, 1'b0);
    fetch_expect("auto_w127", 32'h1FC,   32'hC0DE_007F, 1'b0);
    fetch_req = 1'b0;
    tick();

    // Three-word program with load_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == 2);
      tick();
      if (i < 2) check("prog_nodone", 32'(load_done), 32'd0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("prog_done",   32'(load_done), 32'd1);
    check("prog_lready", 32'(load_ready), 32'd0);

    // Back-to-back fetches
    fetch_expect("f0", 32'h0, prog[0], 1'b0);
    fetch_expect("f4", 32'h4, prog[1], 1'b0);
    fetch_expect("f8", 32'h8, prog[2], 1'b0);
    fetch_req = 1'b0;
    tick();
    check("idle_valid", 32'(fetch_valid), 32'd0);

    // Faults
    fetch_expect("mis2",   32'h2,   32'h0, 1'b1);
    fetch_expect("oor200", 32'h200, 32'h0, 1'b1);
    fetch_expect("top1fc", 32'h1FC, 32'hC0DE_007F, 1'b0);

    // Stall hold
    fetch_expect("stl_acc", 32'h4, 32'h00A1_2820, 1'b0);
    fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'h0 + 32'(i * 6);
      tick();
      check("stl_valid", 32'(fetch_valid), 32'd1);
      check("stl_instr", fetch_instr, 32'h00A1_2820);
      check("stl_fault", 32'(fetch_fault), 32'd0);
    end
    fetch_stall = 1'b0; fetch_req = 1'b0;
    tick();
    check("stl_release", 32'(fetch_valid), 32'd0);

    // load_start colliding with fetch_req
    load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
    #1;
    check("col_fready", 32'(fetch_ready), 32'd0);
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    check("col_valid",  32'(fetch_valid), 32'd0);
    check("col_lready", 32'(load_ready), 32'd1);

    // Two words then reset mid-load
    load_valid = 1'b1; load_data = 32'h1111_1111;
    tick();
    load_data = 32'h2222_2222;
    tick();
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_lready", 32'(load_ready), 32'd0);
    check("mrst_fready", 32'(fetch_ready), 32'd1);
    check("mrst_valid",  32'(fetch_valid), 32'd0);
    check("mrst_instr",  fetch_instr, 32'h0);
    check("mrst_done",   32'(load_done), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check("mrst_nodone", 32'(load_done), 32'd0);
    fetch_expect("mrst_w0", 32'h0, 32'h1111_1111, 1'b0);
    fetch_expect("mrst_w1", 32'h4, 32'h2222_2222, 1'b0);
    fetch_expect("mrst_w2", 32'h8, 32'h00A1_2820, 1'b0);
    fetch_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
